// File: rtl/frame_write_burst_if.sv
// Pixel-stream and write-burst signal bundle of frame_write_burst.
// master: the frame_write_burst side; slave: pixel source plus channel arbiter.
interface frame_write_burst_if #(
  parameter int unsigned MEM_DATA_BITS = 32
);
  logic                     pix_valid;
  logic                     pix_ready;
  logic [MEM_DATA_BITS-1:0] pix_data;
  logic                     wr_burst_req;
  logic [9:0]               wr_burst_len;
  logic [23:0]              wr_burst_addr;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_finish;

  modport master (
    input  pix_valid, pix_data, wr_burst_data_req, wr_burst_finish,
    output pix_ready, wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data
  );

  modport slave (
    output pix_valid, pix_data, wr_burst_data_req, wr_burst_finish,
    input  pix_ready, wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data
  );
endinterface

// File: rtl/frame_write_burst.sv
// Frame write feeder: buffers pixel words in a FWFT FIFO and issues fixed-length write bursts.
// Optional macro FWB_PINGPONG_EN alternates frames between BASE_ADDR0 and BASE_ADDR1.
module frame_write_burst #(
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned FRAME_WORDS   = 76800,
  parameter int unsigned FIFO_DEPTH    = 256,
  parameter logic [23:0] BASE_ADDR0    = 24'h000000,
  parameter logic [23:0] BASE_ADDR1    = 24'h100000
) (
  input  logic                mem_clk,
  input  logic                rst_n,
  input  logic                frame_start,
  frame_write_burst_if.master bus,
  output logic                frame_done,
  output logic                frame_index,
  output logic                underrun_err
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(FRAME_WORDS + 1);
  localparam logic [CNTW-1:0] FIFO_FULL_CNT = FIFO_DEPTH[CNTW-1:0];
  localparam logic [CNTW-1:0] FIFO_BURST    = BURST_LEN[CNTW-1:0];
  localparam logic [CW-1:0]   FRAME_CW      = FRAME_WORDS[CW-1:0];
  localparam logic [CW-1:0]   BURST_CW      = BURST_LEN[CW-1:0];
`ifdef FWB_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif

  typedef enum logic [1:0] {WAIT_SOF, IDLE, BURST} state_t;
  state_t state, state_nxt;

  logic [MEM_DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] fifo_count;
  logic [CW-1:0]   accepted_cnt, written_cnt;
  logic [23:0]     addr_ptr;
  logic            sof_pending, sof_pending_nxt;
  logic            cur_buf, done_q, index_q, underrun_q;
  logic            fifo_empty, fifo_full, push, pop;
  logic            apply_start, burst_end, frame_end;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FIFO_FULL_CNT);

  assign bus.pix_ready = (state != WAIT_SOF) && !sof_pending && !fifo_full &&
                         (accepted_cnt < FRAME_CW);
  assign push = bus.pix_valid && bus.pix_ready;
  assign pop  = bus.wr_burst_data_req && !fifo_empty;

  assign bus.wr_burst_req  = (state == BURST);
  assign bus.wr_burst_len  = 10'(BURST_LEN);
  assign bus.wr_burst_addr = addr_ptr;
  assign bus.wr_burst_data = fifo_mem[rd_ptr];

  assign frame_done   = done_q;
  assign frame_index  = index_q;
  assign underrun_err = underrun_q;

  // A start seen during a burst is parked in sof_pending and applied once back outside BURST.
  always_comb begin
    state_nxt       = state;
    sof_pending_nxt = sof_pending;
    apply_start     = 1'b0;
    burst_end       = 1'b0;
    frame_end       = 1'b0;
    case (state)
      WAIT_SOF, IDLE: begin
        if (frame_start || sof_pending) begin
          apply_start     = 1'b1;
          sof_pending_nxt = 1'b0;
          state_nxt       = IDLE;
        end else if (state == IDLE && fifo_count >= FIFO_BURST) begin
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (frame_start) sof_pending_nxt = 1'b1;
        if (bus.wr_burst_finish) begin
          burst_end = 1'b1;
          frame_end = ((written_cnt + BURST_CW) == FRAME_CW);
          state_nxt = frame_end ? WAIT_SOF : IDLE;
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_SOF;
      sof_pending <= 1'b0;
      addr_ptr    <= BASE_ADDR0;
      written_cnt <= '0;
      cur_buf     <= 1'b1;
      done_q      <= 1'b0;
      index_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      sof_pending <= sof_pending_nxt;
      done_q      <= frame_end;
      if (bus.wr_burst_data_req && fifo_empty) underrun_q <= 1'b1;
      if (frame_end) index_q <= PINGPONG & cur_buf;
      // cur_buf resets to 1 so the first applied start lands on buffer 0.
      if (apply_start) begin
        written_cnt <= '0;
        cur_buf     <= PINGPONG & ~cur_buf;
        addr_ptr    <= (PINGPONG && !cur_buf) ? BASE_ADDR1 : BASE_ADDR0;
      end else if (burst_end) begin
        written_cnt <= written_cnt + BURST_CW;
        addr_ptr    <= addr_ptr + 24'(BURST_LEN);
      end
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      accepted_cnt <= '0;
    end else if (apply_start) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      accepted_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + AW'(1);
        accepted_cnt <= accepted_cnt + CW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.pix_data;
  end

endmodule

// File: tb/tb_frame_write_burst.sv
// Randomized bench for frame_write_burst against a queue-based frame/burst reference model.
module tb_frame_write_burst;

  localparam int unsigned DW    = 32;
  localparam int unsigned BL    = 64;
  localparam int unsigned FW    = 256;
  localparam int unsigned DEPTH = 256;
  localparam logic [23:0] BASE0 = 24'h000000;
  localparam logic [23:0] BASE1 = 24'h100000;
`ifdef FWB_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic mem_clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_start = 1'b0;
  logic frame_done, frame_index, underrun_err;

  frame_write_burst_if #(.MEM_DATA_BITS(DW)) bus ();

  frame_write_burst #(
    .MEM_DATA_BITS(DW), .BURST_LEN(BL), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH),
    .BASE_ADDR0(BASE0), .BASE_ADDR1(BASE1)
  ) dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .frame_start(frame_start), .bus(bus),
    .frame_done(frame_done), .frame_index(frame_index), .underrun_err(underrun_err)
  );

  always #5 mem_clk = ~mem_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: accepted words in order, frame/burst progress as plain counts.
  logic [DW-1:0] mq[$];
  bit          m_waiting, m_burst, m_pending, m_done, m_index, m_underrun, m_buf;
  int          m_accepted, m_written, m_frames;
  logic [23:0] m_base;

  int pops_left, fin_wait, dr_pct;
  bit arb_hold, force_dr;
  bit obs_req, obs_ready, prev_req;
  int dut_bursts, dut_dones, dut_req_cycles;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_waiting = 1; m_burst = 0; m_pending = 0; m_done = 0; m_index = 0;
    m_underrun = 0; m_buf = 0; m_accepted = 0; m_written = 0; m_frames = 0;
    m_base = BASE0; pops_left = 0; fin_wait = 0; prev_req = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    frame_start = 0; bus.pix_valid = 0; bus.wr_burst_data_req = 0; bus.wr_burst_finish = 0;
    #1;
    model_reset();
    check_eq("rst_pix_ready", bus.pix_ready, 0);
    check_eq("rst_req", bus.wr_burst_req, 0);
    check_eq("rst_addr", bus.wr_burst_addr, BASE0);
    check_eq("rst_len", bus.wr_burst_len, BL);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_frame_index", frame_index, 0);
    check_eq("rst_underrun", underrun_err, 0);
    repeat (2) @(posedge mem_clk);
    @(negedge mem_clk) rst_n = 1'b1;
    @(posedge mem_clk);
  endtask

  task automatic cycle(input bit fs, input bit pv);
    bit dr, fin, rdy_exp, pop_ok, push_ok, go_burst;
    logic [DW-1:0] pd;
    @(negedge mem_clk);
    dr = 0; fin = 0;
    if (m_burst) begin
      if (pops_left > 0) dr = !arb_hold && ($urandom_range(99) < dr_pct);
      else if (fin_wait > 0) fin_wait--;
      else fin = 1;
    end
    dr = dr | force_dr;
    pd = $urandom;
    frame_start = fs; bus.pix_valid = pv; bus.pix_data = pd;
    bus.wr_burst_data_req = dr; bus.wr_burst_finish = fin;
    #1;
    rdy_exp = !m_waiting && !m_pending && (mq.size() < DEPTH) && (m_accepted < FW);
    check_eq("pix_ready", bus.pix_ready, rdy_exp);
    check_eq("burst_req", bus.wr_burst_req, m_burst);
    if (m_burst) begin
      check_eq("burst_addr", bus.wr_burst_addr, 24'(m_base + 24'(m_written)));
      check_eq("burst_len", bus.wr_burst_len, BL);
    end
    if (dr && mq.size() != 0) check_eq("burst_data", bus.wr_burst_data, mq[0]);
    check_eq("frame_done", frame_done, m_done);
    check_eq("frame_index", frame_index, m_index);
    check_eq("underrun_err", underrun_err, m_underrun);
    obs_req = bus.wr_burst_req; obs_ready = bus.pix_ready;
    if (obs_req) dut_req_cycles++;
    if (obs_req && !prev_req) dut_bursts++;
    if (frame_done) dut_dones++;
    prev_req = obs_req;

    m_done = 0;
    if (dr && mq.size() == 0) m_underrun = 1;
    pop_ok  = dr && mq.size() != 0;
    push_ok = pv && rdy_exp;
    if (m_burst) begin
      if (fs) m_pending = 1;
      if (pop_ok) void'(mq.pop_front());
      if (dr && pops_left > 0) pops_left--;
      if (push_ok) begin mq.push_back(pd); m_accepted++; end
      if (fin) begin
        m_burst = 0;
        m_written += BL;
        if (m_written == FW) begin
          m_done = 1; m_index = m_buf; m_waiting = 1;
        end
      end
    end else if (fs || m_pending) begin
      mq.delete();
      m_accepted = 0; m_written = 0; m_pending = 0; m_waiting = 0;
      m_buf = PP ? m_frames[0] : 1'b0;
      m_frames++;
      m_base = m_buf ? BASE1 : BASE0;
    end else begin
      go_burst = !m_waiting && mq.size() >= BL;
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) begin mq.push_back(pd); m_accepted++; end
      if (go_burst) begin
        m_burst = 1; pops_left = BL; fin_wait = $urandom_range(2);
      end
    end
    @(posedge mem_clk);
  endtask

  task automatic run_frame(input int pv_pct, input int fs_pct, input int limit, input string tag);
    bit fs_used = 0;
    bit fs;
    for (int i = 0; i < limit; i++) begin
      if (m_waiting && !m_pending) break;
      fs = 0;
      if (m_burst && !fs_used && $urandom_range(99) < fs_pct) begin fs = 1; fs_used = 1; end
      cycle(fs, $urandom_range(99) < pv_pct);
    end
    check_eq({tag, "_completed"}, m_waiting, 1);
    cycle(0, 0);
    cycle(0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, guard;
    bus.pix_valid = 0; bus.pix_data = '0; bus.wr_burst_data_req = 0; bus.wr_burst_finish = 0;
    arb_hold = 0; force_dr = 0; dr_pct = 100;
    do_reset();

    // No frame_start: source pushes continuously, nothing may happen.
    dut_req_cycles = 0;
    repeat (1000) cycle(0, 1);
    check_eq("no_sof_req_cycles", dut_req_cycles, 0);

    // Continuous pixels, arbiter takes a word every cycle.
    dut_bursts = 0; dut_dones = 0;
    cycle(1, 0);
    run_frame(100, 0, 3000, "continuous");
    check_eq("continuous_bursts", dut_bursts, 4);
    check_eq("continuous_dones", dut_dones, 1);

    // Source stalls at 63 words; the 64th triggers the request two cycles later.
    cycle(1, 0);
    guard = 0;
    while (m_accepted < BL - 1 && guard < 500) begin cycle(0, 1); guard++; end
    repeat (20) cycle(0, 0);
    check_eq("stall63_no_req", obs_req, 0);
    cycle(0, 1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 0);
      if (obs_req) begin lat = i; break; end
    end
    check_eq("req_latency", lat, 2);
    run_frame(100, 0, 3000, "stall63");

    // Arbiter holds off until the FIFO is full, then drains.
    arb_hold = 1;
    cycle(1, 0);
    guard = 0;
    while (mq.size() < DEPTH && guard < 600) begin cycle(0, 1); guard++; end
    repeat (5) cycle(0, 1);
    check_eq("full_pix_ready", obs_ready, 0);
    arb_hold = 0;
    run_frame(100, 0, 3000, "fifo_full");

    // Random traffic, occasional frame_start during a burst.
    dr_pct = 60;
    for (int f = 0; f < 6; f++) begin
      cycle(1, 0);
      run_frame(60, 3, 6000, "random");
    end

    // data_req with an empty FIFO sets the sticky underrun flag.
    force_dr = 1;
    cycle(0, 0);
    force_dr = 0;
    repeat (3) cycle(0, 0);
    check_eq("underrun_sticky", underrun_err, 1);

    // Reset asserted in the middle of a burst, then a fresh frame.
    dr_pct = 100;
    cycle(1, 0);
    guard = 0;
    while (!(m_burst && pops_left < 40) && guard < 500) begin cycle(0, 1); guard++; end
    check_eq("midburst_reached", m_burst, 1);
    do_reset();
    cycle(0, 1);
    cycle(1, 0);
    run_frame(100, 0, 3000, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_write_burst.md
# frame_write_burst

Video-side write feeder for one write channel of the DDR memory controller's channel arbiter. Accepts a per-frame stream of MEM_DATA_BITS words and buffers them in an internal FWFT FIFO. Issues fixed-length write bursts (req/len/addr, data_req, finish) at linearly increasing word addresses inside a frame buffer, and signals frame completion. Runs entirely in the controller's phy clock domain; the pixel source must already be synchronised to it.

## Interface
- MEM_DATA_BITS, 32, data word width
- BURST_LEN, 64, words per burst, 1..1023
- FRAME_WORDS, 76800, words per frame; must be a multiple of BURST_LEN
- FIFO_DEPTH, 256, power of two, >= 2*BURST_LEN
- BASE_ADDR0, 24'h000000, frame buffer 0 word address
- BASE_ADDR1, 24'h100000, frame buffer 1 word address (used only with FWB_PINGPONG_EN)

Ports:
- mem_clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse, start of a new frame
- pix_valid  in  1  source word valid
- pix_ready  out  1  block accepts word this cycle
- pix_data  in  MEM_DATA_BITS  source word
- wr_burst_req  out  1  burst request to channel arbiter
- wr_burst_len  out  10  burst length, constant BURST_LEN
- wr_burst_addr  out  24  burst start word address
- wr_burst_data_req  in  1  arbiter consumes one word this cycle
- wr_burst_data  out  MEM_DATA_BITS  FIFO head, combinational
- wr_burst_finish  in  1  burst complete pulse
- frame_done  out  1  one-cycle pulse, last burst of frame finished
- frame_index  out  1  buffer holding the last completed frame
- underrun_err  out  1  sticky: data_req seen with FIFO empty

## Operation
- State machine: WAIT_SOF, IDLE, BURST.
- WAIT_SOF: entered from reset and after frame completion. pix_ready is 0. Leaves on an applied frame_start.
- Applying frame_start:
  - flush the FIFO;
  - clear the accepted-word and written-word counters;
  - set the address pointer to the current base;
  - go to IDLE.
- frame_start arriving in BURST:
  - sets sof_pending; pix_ready is 0 while sof_pending is set;
  - the in-flight burst completes normally;
  - the start is applied on the cycle after wr_burst_finish;
  - the partial frame is abandoned and frame_done is not pulsed.
- frame_start arriving in IDLE or WAIT_SOF is applied on the same edge.
- Accept rule: pix_ready = state!=WAIT_SOF, !sof_pending, FIFO not full, and accepted count < FRAME_WORDS. A word is accepted when pix_valid and pix_ready are both 1.
- IDLE to BURST: when FIFO count >= BURST_LEN and no pending start. On the transition:
  - wr_burst_req rises;
  - wr_burst_addr = pointer;
  - wr_burst_len = BURST_LEN.
- BURST:
  - wr_burst_req, wr_burst_addr and wr_burst_len are held stable until wr_burst_finish.
  - Each cycle wr_burst_data_req=1 pops the FIFO head.
- On wr_burst_finish:
  - wr_burst_req drops;
  - pointer += BURST_LEN (24-bit, wraps mod 2^24);
  - written count += BURST_LEN.
  - If written == FRAME_WORDS: pulse frame_done, update frame_index, go to WAIT_SOF. Otherwise go to IDLE.
- Simultaneous accept and pop in the same cycle: the FIFO count is unchanged.
- data_req while the FIFO is empty: no pop, underrun_err is set (cleared only by reset), and wr_burst_data shows the stale head.

## Timing
- Reset values:
  - pix_ready 0, wr_burst_req 0, wr_burst_addr BASE_ADDR0, wr_burst_len BURST_LEN;
  - wr_burst_data = FIFO RAM content (don't care);
  - frame_done 0, frame_index 0, underrun_err 0;
  - state WAIT_SOF.
- An accepted word is visible in the FIFO count on the next cycle.
- wr_burst_req rises 1 cycle after the count first reaches BURST_LEN.
- wr_burst_data is valid combinationally from the FIFO head in the same cycle as data_req. The next head is presented the following cycle.
- frame_done is registered: 1 cycle after the final wr_burst_finish.
- Minimum gap between bursts: 1 IDLE cycle after finish.
- Reset asserted mid-burst: all outputs return to reset values asynchronously. The FIFO is emptied.

## Configuration
- FWB_PINGPONG_EN defined:
  - each applied frame_start selects the base not written by the previous frame (first after reset: BASE_ADDR0);
  - frame_index = buffer of the last completed frame, updated with frame_done.
- Not defined: the base is always BASE_ADDR0, frame_index is constant 0, and BASE_ADDR1 is unused.

## Test plan
- Reset then continuous pix_valid without frame_start:
  - pix_ready stays 0;
  - no wr_burst_req for 1000 cycles.
- BURST_LEN=64, FRAME_WORDS=256, continuous pixels after frame_start, data_req every cycle after req:
  - 4 bursts at addresses 0, 64, 128, 192;
  - data matches input order;
  - one frame_done;
  - then WAIT_SOF.
- Source stalls with FIFO at 63 words:
  - no req;
  - the 64th word triggers req exactly 2 cycles after its acceptance.
- Arbiter stalls data_req until the FIFO is full:
  - pix_ready = 0 at 256 words;
  - no loss or duplication after resume.
- frame_start mid-burst:
  - req is held until finish;
  - the next burst restarts at the base address with the flushed FIFO;
  - no frame_done.
- With FWB_PINGPONG_EN, two full frames:
  - the second frame's addresses start at 24'h100000;
  - frame_index reads 0 then 1 after each frame_done.
